// File: rtl/cpu_regfile.sv
// Parametrised register file: one write port, two combinational read ports with
// write-through bypass, optional hardwired-zero entry 0, and a sequenced bulk clear.
module cpu_regfile #(
  parameter int                WIDTH     = 8,
  parameter int                DEPTH     = 8,
  parameter int                AW        = $clog2(DEPTH),
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                ZERO_REG  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  input  logic             clr_req,
  output logic             busy,
  output logic             clr_done
);

  // One extra bit so DEPTH itself is representable when DEPTH is a power of 2.
  localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             busy_q, busy_d;
  logic             clr_done_q, clr_done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             wr_accept;
  logic             sweep_en;

  assign wr_accept = we && !busy_q && ({1'b0, waddr} < DEPTH_W)
                     && !(ZERO_REG && (waddr == '0));
  assign sweep_en  = (state_q == S_SWEEP);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          state_d = S_SWEEP;
          idx_d   = '0;
        end
      end
      S_SWEEP: begin
        if (idx_q == LAST_IDX) state_d = S_DONE;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d     = (state_d == S_SWEEP);
    clr_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
    end
  end

  // Sweep and host write never collide: writes are blocked while busy.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (sweep_en && (idx_q == AW'(i)))
        mem_d[i] = RESET_VAL;
      else if (wr_accept && (waddr == AW'(i)))
        mem_d[i] = wdata;
    end
    if (ZERO_REG) mem_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= (ZERO_REG && (i == 0)) ? '0 : RESET_VAL;
    end else begin
      mem_q <= mem_d;
    end
  end

  logic [AW-1:0]    raddr_p [2];
  logic [WIDTH-1:0] rdata_p [2];

  assign raddr_p[0] = raddr_a;
  assign raddr_p[1] = raddr_b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic in_range;
      logic is_zero;
      logic bypass;
      assign in_range    = ({1'b0, raddr_p[gi]} < DEPTH_W);
      assign is_zero     = ZERO_REG && (raddr_p[gi] == '0);
      assign bypass      = wr_accept && (raddr_p[gi] == waddr);
      assign rdata_p[gi] = (!in_range || is_zero) ? '0
                         : bypass                 ? wdata
                         :                          mem_q[raddr_p[gi]];
    end
  endgenerate

  assign rdata_a  = rdata_p[0];
  assign rdata_b  = rdata_p[1];
  assign busy     = busy_q;
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed bench for cpu_regfile: three instances (plain, zero-register, DEPTH=5)
// share one stimulus stream; each output is compared against hand-derived values.
module tb_cpu_regfile;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic       clr_req;

  logic [7:0] rd_a0, rd_b0, rd_a1, rd_b1, rd_a2, rd_b2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_regfile #(.WIDTH(8), .DEPTH(8), .RESET_VAL(8'h5A), .ZERO_REG(1'b0)) u_plain (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rd_a0), .raddr_b(raddr_b), .rdata_b(rd_b0),
    .clr_req(clr_req), .busy(busy0), .clr_done(done0)
  );

  cpu_regfile #(.WIDTH(8), .DEPTH(8), .RESET_VAL(8'h5A), .ZERO_REG(1'b1)) u_zero (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rd_a1), .raddr_b(raddr_b), .rdata_b(rd_b1),
    .clr_req(clr_req), .busy(busy1), .clr_done(done1)
  );

  cpu_regfile #(.WIDTH(8), .DEPTH(5), .RESET_VAL(8'h5A), .ZERO_REG(1'b0)) u_odd (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rd_a2), .raddr_b(raddr_b), .rdata_b(rd_b2),
    .clr_req(clr_req), .busy(busy2), .clr_done(done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    we    = 1'b1;
    waddr = 3'(addr);
    wdata = 8'(data);
    tick();
    we    = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
    raddr_a = '0; raddr_b = '0; clr_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state
    check("rst_busy0", busy0, 0);
    check("rst_done0", done0, 0);
    check("rst_busy2", busy2, 0);
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      check($sformatf("rst_plain_e%0d", i), rd_a0, 8'h5A);
    end
    raddr_a = 3'd0; #1;
    check("rst_zero_e0", rd_a1, 0);

    // Write then reset restores RESET_VAL
    wr(3, 8'h11);
    raddr_a = 3'd3; #1;
    check("wr_e3", rd_a0, 8'h11);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    check("rst2_plain_e3", rd_a0, 8'h5A);
    check("rst2_zero_e3", rd_a1, 8'h5A);
    check("rst2_odd_e3", rd_a2, 8'h5A);
    check("rst2_busy0", busy0, 0);
    check("rst2_done0", done0, 0);

    // Write-through bypass on both ports
    we = 1'b1; waddr = 3'd2; wdata = 8'hC3; raddr_a = 3'd2; #1;
    check("byp_a_same_cycle", rd_a0, 8'hC3);
    tick(); we = 1'b0; #1;
    check("byp_a_held", rd_a0, 8'hC3);
    we = 1'b1; wdata = 8'h3C; raddr_b = 3'd2; #1;
    check("byp_b_same_cycle", rd_b0, 8'h3C);
    check("byp_a_same_cycle2", rd_a0, 8'h3C);
    check("byp_b_odd", rd_b2, 8'h3C);
    tick(); we = 1'b0; #1;
    check("byp_b_held", rd_b0, 8'h3C);

    // Hardwired zero register
    we = 1'b1; waddr = 3'd0; wdata = 8'hFF; raddr_a = 3'd0; #1;
    check("zr_write_cycle", rd_a1, 0);
    check("plain_e0_bypass", rd_a0, 8'hFF);
    tick(); we = 1'b0; #1;
    check("zr_after", rd_a1, 0);
    check("plain_e0_after", rd_a0, 8'hFF);

    // Out-of-range address on DEPTH=5
    we = 1'b1; waddr = 3'd6; wdata = 8'h77; raddr_a = 3'd6; #1;
    check("odd_oor_no_bypass", rd_a2, 0);
    check("plain_e6_bypass", rd_a0, 8'h77);
    tick(); we = 1'b0; #1;
    check("odd_oor_read", rd_a2, 0);
    check("plain_e6_after", rd_a0, 8'h77);

    // Bulk clear
    for (int i = 0; i < 8; i++) wr(i, 8'h10 + i);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check($sformatf("clr_busy0_k%0d", k), busy0, (k < 8) ? 1 : 0);
      check($sformatf("clr_done0_k%0d", k), done0, (k == 8) ? 1 : 0);
      check($sformatf("clr_busy2_k%0d", k), busy2, (k < 5) ? 1 : 0);
      check($sformatf("clr_done2_k%0d", k), done2, (k == 5) ? 1 : 0);
      if (k < 8) begin
        raddr_a = 3'(k);
        raddr_b = (k == 0) ? 3'd0 : 3'(k - 1);
        #1;
        check($sformatf("clr_pending_e%0d", k), rd_a0, 8'h10 + k);
        if (k > 0) check($sformatf("clr_done_e%0d", k - 1), rd_b0, 8'h5A);
      end
      if (k == 2) begin
        we = 1'b1; waddr = 3'd7; wdata = 8'hAA; raddr_a = 3'd7; #1;
        check("clr_busy_write_no_bypass", rd_a0, 8'h17);
      end
      tick();
      we = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      raddr_a = 3'(i);
      #1;
      check($sformatf("clr_final_plain_e%0d", i), rd_a0, 8'h5A);
      check($sformatf("clr_final_zero_e%0d", i), rd_a1, (i == 0) ? 0 : 8'h5A);
      check($sformatf("clr_final_odd_e%0d", i), rd_a2, (i < 5) ? 8'h5A : 0);
    end

    // Mid-sweep reset aborts without a done pulse
    wr(6, 8'h99);
    raddr_a = 3'd6; #1;
    check("pre_abort_e6", rd_a0, 8'h99);
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    tick(); tick(); tick();
    check("abort_busy_before", busy0, 1);
    rst = 1'b1; tick(); rst = 1'b0; #1;
    check("abort_busy_after", busy0, 0);
    check("abort_e6", rd_a0, 8'h5A);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("abort_no_done_k%0d", k), done0, 0);
      tick();
    end

    // Held clr_req: full sweep, done, one idle cycle, then a new sweep
    clr_req = 1'b1;
    tick();
    for (int k = 0; k <= 10; k++) begin
      check($sformatf("hold_busy0_k%0d", k), busy0, ((k < 8) || (k == 10)) ? 1 : 0);
      check($sformatf("hold_done0_k%0d", k), done0, (k == 8) ? 1 : 0);
      check($sformatf("hold_busy1_k%0d", k), busy1, ((k < 8) || (k == 10)) ? 1 : 0);
      check($sformatf("hold_busy2_k%0d", k), busy2, ((k < 5) || (k >= 7)) ? 1 : 0);
      check($sformatf("hold_done2_k%0d", k), done2, (k == 5) ? 1 : 0);
      tick();
    end
    clr_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_regfile.md
Name: cpu_regfile

Overview:
- Parametrised general-purpose register file for the CPU datapath.
- Generalises the single 8-bit enabled register to DEPTH entries of WIDTH bits.
- Provides 1 write port and 2 combinational read ports with write-through bypass, plus an optional hardwired-zero register 0.
- Adds a sequenced bulk-clear operation driven by a small state machine, so software can wipe the file without a full reset.

Parameters:
- WIDTH, 8, data width of each register.
- DEPTH, 8, number of registers (≥2; need not be a power of 2).
- AW, $clog2(DEPTH), address width (derived; do not override).
- RESET_VAL, 0, value loaded into every entry by reset and by bulk clear (WIDTH bits).
- ZERO_REG, 0, when 1, entry 0 always reads 0 and ignores writes.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- raddr_a  in  AW  read address, port A.
- rdata_a  out  WIDTH  read data, port A (combinational).
- raddr_b  in  AW  read address, port B.
- rdata_b  out  WIDTH  read data, port B (combinational).
- clr_req  in  1  request bulk clear (level sampled; acted on only in IDLE).
- busy  out  1  high while the bulk clear is in progress.
- clr_done  out  1  one-cycle pulse when the bulk clear completes.

Behaviour:
- Reset:
  - rst=1 at a posedge sets every entry to RESET_VAL, state to IDLE, sweep index to 0, busy=0 and clr_done=0.
  - Reset takes priority over all other inputs.
- Write:
  - When we=1, busy=0 and waddr < DEPTH, entry[waddr] takes wdata at the posedge.
  - The new value is visible in the array from the next cycle.
  - When we=0, all entries hold.
- Write ignored when any of these holds:
  - busy=1;
  - waddr ≥ DEPTH;
  - ZERO_REG=1 and waddr=0.
- Read:
  - rdata_x = entry[raddr_x], combinational, 0-cycle latency.
  - raddr_x ≥ DEPTH reads 0.
  - ZERO_REG=1 and raddr_x=0 reads 0.
- Bypass:
  - If a write is accepted this cycle and raddr_x == waddr, rdata_x = wdata in the same cycle.
  - Applies to both ports independently.
  - Never bypasses an ignored write.
- FSM states: IDLE, SWEEP, DONE.
- FSM transitions:
  - IDLE: clr_req=1 → SWEEP, idx←0.
  - SWEEP: entry[idx]←RESET_VAL each cycle (entry 0 stays 0 when ZERO_REG=1). If idx==DEPTH-1 → DONE, else idx←idx+1.
  - DONE: → IDLE unconditionally.
- FSM outputs:
  - busy=1 exactly in SWEEP.
  - clr_done=1 exactly in DONE.
  - Both are registered state decodes.
- Clear timing:
  - clr_req sampled high at edge E: busy is high for exactly DEPTH cycles after E.
  - Entry i is cleared at edge E+1+i.
  - clr_done is high for the single cycle following edge E+DEPTH; busy=0 in that cycle.
- Clear boundary conditions:
  - clr_req while in SWEEP or DONE is ignored; no queuing.
  - clr_req held high re-triggers only once the FSM is back in IDLE.
  - clr_req and we together in IDLE: the write is accepted this edge and the sweep starts next cycle, so the written entry is later cleared.
  - rst during SWEEP aborts the sweep. All entries go to RESET_VAL, FSM goes to IDLE, and no clr_done pulse is produced.
  - Reads during SWEEP return current array contents, whether already cleared or not; there is no bypass because writes are ignored.
  - The idx counter must not exceed DEPTH-1 for non-power-of-2 DEPTH.

Test Plan:
- Reset: WIDTH=8, DEPTH=8, RESET_VAL=8'h5A. Write 8'h11 to entry 3, then assert rst for 1 cycle → all reads return 8'h5A next cycle; busy=0, clr_done=0.
- Write/read/bypass: we=1, waddr=2, wdata=8'hC3, raddr_a=2 → rdata_a=8'hC3 in the same cycle. With we=0 next cycle → rdata_a still 8'hC3. Then raddr_b=2 with we=1, wdata=8'h3C → rdata_b=8'h3C combinationally.
- Zero register: ZERO_REG=1, write 8'hFF to entry 0 → rdata_a(raddr 0)=0 both in the write cycle and after.
- Bulk clear: fill entries 0..7 with 8'h10..8'h17, pulse clr_req at edge E → busy high for 8 cycles. During busy, a write of 8'hAA to entry 7 is ignored. clr_done pulses once, then all entries read RESET_VAL.
- Mid-sweep reset and retrigger: assert rst 3 cycles into the sweep → busy=0 next cycle, no clr_done. Then hold clr_req high continuously → one full sweep, clr_done pulse, back to IDLE, and a second sweep begins the cycle after.
- Non-power-of-2: DEPTH=5 (AW=3). Write to waddr=6 is ignored and raddr 6 reads 0. A sweep lasts exactly 5 busy cycles.
